instr_cache_ctrl: RTL and testbench
===================================

// Module: instr_cache_ctrl
// PURPOSE
//  Direct-mapped instruction cache and refill controller feeding the fetch stage's PC-indexed instruction path.
//  Returns the instruction and a hit flag in the same cycle as the lookup.
//  On a miss it refills one full line from backing instruction memory over a req/rvalid handshake.
//  hit drives the stall input of all pipeline registers: 0 = hold.
// PARAMETERS
//  LINES      16   number of cache lines (power of 2, >=2)
//  WORDS      4    32-bit words per line (power of 2, >=2)
//  NOP_INSTR  32'h00000013  value driven on instr while hit=0
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  pc_addr    in   32  byte address of requested instruction (bits[1:0] ignored)
//  pc_valid   in   1   lookup request this cycle
//  flush      in   1   invalidate all lines
//  instr      out  32  instruction word at pc_addr when hit=1, else NOP_INSTR
//  hit        out  1   1 = instr valid this cycle; 0 = pipeline must stall
//  mem_req    out  1   word read request to backing memory
//  mem_addr   out  32  word-aligned byte address of requested word
//  mem_rdata  in   32  returned word
//  mem_rvalid in   1   mem_rdata valid; completes the current mem_req
// BEHAVIOUR
//  Address split:
//   - OFF = log2(WORDS)+2 (low bits); IDX = log2(LINES) (index bits above OFF)
//   - TAG = 32-IDX-OFF (remaining high bits)
//   - Storage: data[LINES*WORDS], tag[LINES], valid[LINES]
//  Reset: state=IDLE, all valid=0, word counter=0, mem_req=0, mem_addr=0, hit=0, instr=NOP_INSTR.
//   - Data/tag arrays are not reset.
//  State IDLE:
//   - hit = pc_valid & valid[idx] & (tag[idx]==pc tag) & ~flush (combinational, same cycle).
//   - instr = data word selected by idx and word offset when hit, else NOP_INSTR.
//   - On pc_valid & ~hit & ~flush: latch line base (pc_addr with low OFF bits cleared) and clear counter k.
//     Next state is REFILL.
//   - pc_valid=0 -> hit=0, no action.
//  State REFILL:
//   - hit=0 throughout.
//   - mem_req=1, mem_addr = line_base + 4*k; both held stable until mem_rvalid=1.
//   - mem_rvalid may assert in the same cycle as mem_req (zero-wait memory).
//   - On each mem_rvalid: data[idx][k] <= mem_rdata, k <= k+1.
//   - On the last word (k==WORDS-1): tag[idx] <= latched tag, valid[idx] <= 1, mem_req deasserts next cycle.
//     Next state is IDLE; lookup retries the (held) PC and hits.
//   - Miss penalty with zero-wait memory: 1+WORDS cycles (first lookup through return to IDLE).
//   - mem_rvalid while not in REFILL is ignored.
//  pc_addr changes during REFILL: ignored; the refill of the latched line completes.
//   - The new PC is looked up in IDLE.
//  Flush:
//   - In IDLE: all valid <= 0 next edge; hit forced 0 that cycle.
//   - During REFILL: all valid <= 0; the in-flight refill writes data but does not set valid.
//     Remembered via flush_pending, cleared on return to IDLE.
//   - Flush takes priority over the valid set when it coincides with the last word.
//  Reset mid-REFILL: abandon immediately.
//   - mem_req=0 next cycle, valid all 0; outstanding mem_rvalid ignored.
//  Counter k is log2(WORDS) bits; wraps to 0 after the last word.
// TESTING
//  T1 reset:
//   - Stimulus: rst=1 for 2 cycles, pc_valid=1, pc_addr=0.
//   - Response: hit=0, instr=32'h13, mem_req=0.
//   - Then the first IDLE cycle misses.
//  T2 cold miss, zero-wait memory returning addr^32'hA5A50000:
//   - Stimulus: pc_addr=0x40.
//   - Response: mem_addr 0x40,0x44,0x48,0x4C on 4 consecutive cycles.
//   - hit=1 with instr=0xA5A50040 on cycle 6.
//  T3 hits across line:
//   - Stimulus: after T2, pc 0x44,0x48,0x4C.
//   - Response: hit=1 each cycle, instr=0xA5A50044/48/4C, mem_req stays 0.
//  T4 conflict miss:
//   - Stimulus: pc=0x40+LINES*WORDS*4 (same index, new tag), memory latency 3 cycles/word.
//   - Response: hit=0 for 1+4*3 cycles, then hit with new data.
//   - Then pc=0x40 misses again.
//  T5 flush:
//   - Stimulus: flush during word 2 of a refill.
//   - Response: refill finishes (4 requests), but the following lookup of the same PC misses and re-refills.
//  T6 reset mid-refill:
//   - Stimulus: rst asserted after word 1, mem_rvalid pulsed afterwards.
//   - Response: mem_req=0 next cycle, no array update, next lookup misses.

Source files
------------

// File: rtl/instr_cache_ctrl.sv
// rtl/instr_cache_ctrl.sv - direct-mapped instruction cache with single-line refill controller
module instr_cache_ctrl #(
    parameter int          LINES     = 16,
    parameter int          WORDS     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_addr,
    input  logic        pc_valid,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int WB  = $clog2(WORDS);
    localparam int OFF = WB + 2;
    localparam int IB  = $clog2(LINES);
    localparam int TB  = 32 - IB - OFF;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_REFILL = 1'b1;

    logic [0:0]       state;
    logic [LINES-1:0] valid;
    logic [WB-1:0]    k;
    logic [31-OFF:0]  line_hi;
    logic             flush_pending;

    logic [31:0]      data_mem [LINES*WORDS];
    logic [TB-1:0]    tag_mem  [LINES];

    logic [IB-1:0]    pc_idx;
    logic [WB-1:0]    pc_word;
    logic [TB-1:0]    pc_tag;
    logic [IB-1:0]    ref_idx;
    logic [TB-1:0]    ref_tag;
    logic [IB+WB-1:0] rd_ptr;
    logic [IB+WB-1:0] wr_ptr;
    logic             lookup_hit;
    logic             last_word;
    logic             refill_beat;
    logic [1:0]       unused_pc_bits;

    assign pc_idx         = pc_addr[OFF +: IB];
    assign pc_word        = pc_addr[2 +: WB];
    assign pc_tag         = pc_addr[31 -: TB];
    assign unused_pc_bits = pc_addr[1:0];

    // line_hi holds {tag, index} of the line being refilled
    assign ref_idx = line_hi[IB-1:0];
    assign ref_tag = line_hi[31-OFF -: TB];

    assign rd_ptr = {pc_idx, pc_word};
    assign wr_ptr = {ref_idx, k};

    assign last_word   = (k == WB'(WORDS - 1));
    assign refill_beat = (state == S_REFILL) && mem_rvalid;

    always_comb begin
        lookup_hit = 1'b0;
        if (state == S_IDLE && pc_valid && !flush && valid[pc_idx]) begin
            lookup_hit = (tag_mem[pc_idx] == pc_tag);
        end
    end

    assign hit   = lookup_hit;
    assign instr = lookup_hit ? data_mem[rd_ptr] : NOP_INSTR;

    assign mem_req  = (state == S_REFILL);
    assign mem_addr = (state == S_REFILL) ? {line_hi, k, 2'b00} : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            valid         <= '0;
            k             <= '0;
            line_hi       <= '0;
            flush_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        valid <= '0;
                    end
                    if (pc_valid && !lookup_hit && !flush) begin
                        line_hi <= pc_addr[31:OFF];
                        k       <= '0;
                        state   <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (flush) begin
                        valid         <= '0;
                        flush_pending <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        k <= k + 1'b1;
                        if (last_word) begin
                            state         <= S_IDLE;
                            flush_pending <= 1'b0;
                            // a flush seen at any point of this refill keeps the line invalid
                            if (!flush && !flush_pending) begin
                                valid[ref_idx] <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && refill_beat) begin
            data_mem[wr_ptr] <= mem_rdata;
            if (last_word) begin
                tag_mem[ref_idx] <= ref_tag;
            end
        end
    end

endmodule

// File: tb/tb_instr_cache_ctrl.sv
// tb/tb_instr_cache_ctrl.sv - directed self-checking bench for instr_cache_ctrl
module tb_instr_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        pc_valid;
    logic        flush;
    logic [31:0] instr;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int   n_chk   = 0;
    int   n_fail  = 0;
    int   lat     = 1;
    int   wcnt    = 0;
    int   n_words = 0;
    int   w0      = 0;
    logic mem_en  = 1'b0;
    logic pulse   = 1'b0;

    instr_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .pc_addr    (pc_addr),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .instr      (instr),
        .hit        (hit),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    always #5 clk = ~clk;

    // backing memory: data = addr ^ A5A50000, answers on the lat-th cycle of each request
    assign mem_rvalid = (mem_en && mem_req && (wcnt == lat - 1)) || pulse;
    assign mem_rdata  = mem_addr ^ 32'hA5A50000;

    always @(posedge clk) begin
        if (rst || !mem_req || mem_rvalid) wcnt <= 0;
        else wcnt <= wcnt + 1;
        if (!rst && mem_req && mem_rvalid) n_words <= n_words + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_hit(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            smp();
            if (hit === 1'b1) begin
                found = 1'b1;
                break;
            end
            next_cyc();
        end
        check(tag, {31'b0, found}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pc_valid = 1'b1; pc_addr = 32'h0; flush = 1'b0;
        mem_en = 1'b1; lat = 1; pulse = 1'b0;

        // T1 reset
        next_cyc();
        smp();
        check("t1_hit", {31'b0, hit}, 32'd0);
        check("t1_instr", instr, 32'h00000013);
        check("t1_mem_req", {31'b0, mem_req}, 32'd0);
        check("t1_mem_addr", mem_addr, 32'h0);
        next_cyc();
        rst = 1'b0;
        smp();
        check("t1_first_idle_miss", {31'b0, hit}, 32'd0);
        check("t1_first_idle_instr", instr, 32'h00000013);
        next_cyc();
        wait_hit("t1_line0_refill_done");
        check("t1_line0_instr", instr, 32'hA5A50000);

        // T2 cold miss at 0x40, zero-wait memory
        next_cyc();
        pc_addr = 32'h40;
        smp();
        check("t2_c1_hit", {31'b0, hit}, 32'd0);
        check("t2_c1_mem_req", {31'b0, mem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cyc();
            smp();
            check("t2_req", {31'b0, mem_req}, 32'd1);
            check("t2_addr", mem_addr, 32'h40 + 32'(4 * i));
            check("t2_refill_hit", {31'b0, hit}, 32'd0);
        end
        next_cyc();
        smp();
        check("t2_c6_hit", {31'b0, hit}, 32'd1);
        check("t2_c6_instr", instr, 32'hA5A50040);

        // T3 hits across the line
        for (int w = 1; w < 4; w++) begin
            next_cyc();
            pc_addr = 32'h40 + 32'(4 * w);
            smp();
            check("t3_hit", {31'b0, hit}, 32'd1);
            check("t3_instr", instr, 32'hA5A50040 + 32'(4 * w));
            check("t3_mem_req", {31'b0, mem_req}, 32'd0);
        end

        // T4 conflict miss, 3 cycles per word
        next_cyc();
        pc_addr = 32'h140; lat = 3;
        smp();
        check("t4_c1_hit", {31'b0, hit}, 32'd0);
        for (int i = 1; i <= 12; i++) begin
            next_cyc();
            smp();
            check("t4_stall", {31'b0, hit}, 32'd0);
            if (i == 1) check("t4_first_addr", mem_addr, 32'h140);
            if (i == 12) check("t4_last_addr", mem_addr, 32'h14C);
        end
        next_cyc();
        smp();
        check("t4_hit_new", {31'b0, hit}, 32'd1);
        check("t4_instr_new", instr, 32'hA5A50140);
        next_cyc();
        pc_addr = 32'h40; lat = 1;
        smp();
        check("t4_old_evicted", {31'b0, hit}, 32'd0);
        next_cyc();
        wait_hit("t4_old_refill_done");
        check("t4_old_instr", instr, 32'hA5A50040);

        // T5 flush during word 2 of a refill
        next_cyc();
        pc_addr = 32'h80; w0 = n_words;
        smp();
        check("t5_c1_miss", {31'b0, hit}, 32'd0);
        next_cyc();
        next_cyc();
        next_cyc();
        flush = 1'b1;
        smp();
        check("t5_flush_word2_addr", mem_addr, 32'h88);
        next_cyc();
        flush = 1'b0;
        smp();
        check("t5_word3_addr", mem_addr, 32'h8C);
        next_cyc();
        smp();
        check("t5_post_flush_miss", {31'b0, hit}, 32'd0);
        check("t5_words_fetched", 32'(n_words - w0), 32'd4);
        next_cyc();
        smp();
        check("t5_rerefill_req", {31'b0, mem_req}, 32'd1);
        check("t5_rerefill_addr", mem_addr, 32'h80);
        next_cyc();
        wait_hit("t5_rerefill_done");
        check("t5_instr", instr, 32'hA5A50080);

        // flush while idle: forced miss, no refill launched from that cycle
        next_cyc();
        flush = 1'b1;
        smp();
        check("t5_idle_flush_hit", {31'b0, hit}, 32'd0);
        check("t5_idle_flush_instr", instr, 32'h00000013);
        next_cyc();
        flush = 1'b0;
        smp();
        check("t5_after_flush_miss", {31'b0, hit}, 32'd0);
        check("t5_after_flush_no_req", {31'b0, mem_req}, 32'd0);
        next_cyc();
        smp();
        check("t5_after_flush_req", {31'b0, mem_req}, 32'd1);
        next_cyc();
        wait_hit("t5_after_flush_refill");
        next_cyc();
        pc_addr = 32'h140;
        smp();
        check("t5_other_line_flushed", {31'b0, hit}, 32'd0);
        next_cyc();
        wait_hit("t5_other_line_refill");

        // T6 reset mid-refill, stray rvalid afterwards
        next_cyc();
        pc_addr = 32'hC0;
        smp();
        check("t6_c1_miss", {31'b0, hit}, 32'd0);
        next_cyc();
        next_cyc();
        rst = 1'b1; mem_en = 1'b0;
        smp();
        next_cyc();
        rst = 1'b0; pc_valid = 1'b0; pulse = 1'b1; mem_en = 1'b1;
        smp();
        check("t6_req_dropped", {31'b0, mem_req}, 32'd0);
        check("t6_no_hit", {31'b0, hit}, 32'd0);
        next_cyc();
        pulse = 1'b0; pc_valid = 1'b1; pc_addr = 32'h40;
        smp();
        check("t6_valid_cleared", {31'b0, hit}, 32'd0);
        next_cyc();
        smp();
        check("t6_refill_restart_req", {31'b0, mem_req}, 32'd1);
        check("t6_refill_restart_addr", mem_addr, 32'h40);
        next_cyc();
        wait_hit("t6_refill_done");
        check("t6_instr", instr, 32'hA5A50040);
        next_cyc();
        pc_addr = 32'hC0;
        smp();
        check("t6_aborted_line_miss", {31'b0, hit}, 32'd0);
        next_cyc();
        wait_hit("t6_c0_refill_done");
        check("t6_c0_instr", instr, 32'hA5A500C0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
